// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl shared definitions
// Default widths and FSM state encodings used across the block.
package alu_issue_ctrl_pkg;

    localparam int DATA_WIDTH_DEF     = 32;
    localparam int ALU_OPRN_WIDTH_DEF = 6;
    localparam int REG_ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl bus interface
// Request, response and external ALU signals in one bundle.
interface alu_issue_ctrl_if
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ALU_OPRN_WIDTH = ALU_OPRN_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
);

    logic                      REQ_VALID;
    logic                      REQ_READY;
    logic [ALU_OPRN_WIDTH-1:0] REQ_OPRN;
    logic [REG_ADDR_WIDTH-1:0] REQ_RS1;
    logic [REG_ADDR_WIDTH-1:0] REQ_RS2;
    logic [REG_ADDR_WIDTH-1:0] REQ_RD;
    logic                      REQ_IMM_SEL;
    logic [DATA_WIDTH-1:0]     REQ_IMM;

    logic [DATA_WIDTH-1:0]     ALU_OP1;
    logic [DATA_WIDTH-1:0]     ALU_OP2;
    logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN;
    logic [DATA_WIDTH-1:0]     ALU_RESULT;

    logic                      RSP_VALID;
    logic                      RSP_READY;
    logic [DATA_WIDTH-1:0]     RSP_DATA;
    logic [REG_ADDR_WIDTH-1:0] RSP_RD;

    modport master (
        output REQ_VALID, REQ_OPRN, REQ_RS1, REQ_RS2, REQ_RD,
        output REQ_IMM_SEL, REQ_IMM,
        input  REQ_READY,
        input  ALU_OP1, ALU_OP2, ALU_OPRN,
        output ALU_RESULT,
        input  RSP_VALID, RSP_DATA, RSP_RD,
        output RSP_READY
    );

    modport slave (
        input  REQ_VALID, REQ_OPRN, REQ_RS1, REQ_RS2, REQ_RD,
        input  REQ_IMM_SEL, REQ_IMM,
        output REQ_READY,
        output ALU_OP1, ALU_OP2, ALU_OPRN,
        input  ALU_RESULT,
        output RSP_VALID, RSP_DATA, RSP_RD,
        input  RSP_READY
    );

endinterface

// File: rtl/alu_issue_ctrl_register_file.sv
// alu_issue_ctrl register file
// Two async read ports, one sync write port, R0 reads as zero.
module alu_issue_ctrl_register_file
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0]     rdata1_o,
    output logic [DATA_WIDTH-1:0]     rdata2_o,
    input  logic                      we_i,
    input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i
);

    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREG];

    // Storage: cleared on reset, writes to R0 dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl top
// Sequences one ALU op: accept, load operands, execute, respond.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ALU_OPRN_WIDTH = ALU_OPRN_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    alu_issue_ctrl_if.slave io
);

    state_e state_q, state_d;

    logic [ALU_OPRN_WIDTH-1:0] oprn_q, oprn_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      imm_sel_q, imm_sel_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;

    logic [DATA_WIDTH-1:0]     op1_q, op1_d;
    logic [DATA_WIDTH-1:0]     op2_q, op2_d;
    logic [ALU_OPRN_WIDTH-1:0] aoprn_q, aoprn_d;
    logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic [REG_ADDR_WIDTH-1:0] rsp_rd_q, rsp_rd_d;

    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic                  accept;
    logic                  rf_we;

    assign accept = io.REQ_VALID && (state_q == IDLE);
    assign rf_we  = (state_q == EXEC);

    alu_issue_ctrl_register_file #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_register_file (
        .clk_i    (CLK),
        .rst_i    (RST),
        .raddr1_i (rs1_q),
        .raddr2_i (rs2_q),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2),
        .we_i     (rf_we),
        .waddr_i  (rd_q),
        .wdata_i  (io.ALU_RESULT)
    );

    // FSM next state: single op in flight, response waits for ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (io.REQ_VALID) state_d = LOAD;
            LOAD:    state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (io.RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: each field updates only on its own edge
    always_comb begin
        oprn_d     = oprn_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        imm_sel_d  = imm_sel_q;
        imm_d      = imm_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        aoprn_d    = aoprn_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
        if (accept) begin
            oprn_d    = io.REQ_OPRN;
            rs1_d     = io.REQ_RS1;
            rs2_d     = io.REQ_RS2;
            rd_d      = io.REQ_RD;
            imm_sel_d = io.REQ_IMM_SEL;
            imm_d     = io.REQ_IMM;
        end
        if (state_q == LOAD) begin
            op1_d   = rdata1;
            op2_d   = imm_sel_q ? imm_q : rdata2;
            aoprn_d = oprn_q;
        end
        if (state_q == EXEC) begin
            rsp_data_d = io.ALU_RESULT;
            rsp_rd_d   = rd_q;
        end
    end

    // State and datapath registers, all cleared by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            oprn_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            imm_sel_q  <= 1'b0;
            imm_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            aoprn_q    <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            oprn_q     <= oprn_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            imm_sel_q  <= imm_sel_d;
            imm_q      <= imm_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            aoprn_q    <= aoprn_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
        end
    end

    assign io.REQ_READY = (state_q == IDLE);
    assign io.RSP_VALID = (state_q == RESP);
    assign io.RSP_DATA  = rsp_data_q;
    assign io.RSP_RD    = rsp_rd_q;
    assign io.ALU_OP1   = op1_q;
    assign io.ALU_OP2   = op2_q;
    assign io.ALU_OPRN  = aoprn_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// alu_issue_ctrl testbench
// Directed vectors against a small external ALU model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .io  (bus)
    );

    function automatic logic [31:0] alu_model(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [5:0]  op
    );
        case (op)
            6'h01:   return a + b;
            6'h02:   return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign bus.ALU_RESULT = alu_model(bus.ALU_OP1, bus.ALU_OP2, bus.ALU_OPRN);

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [5:0] oprn, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic imm_sel,
                             input logic [31:0] imm, input logic [4:0] rd);
        bus.REQ_OPRN    = oprn;
        bus.REQ_RS1     = rs1;
        bus.REQ_RS2     = rs2;
        bus.REQ_IMM_SEL = imm_sel;
        bus.REQ_IMM     = imm;
        bus.REQ_RD      = rd;
        bus.REQ_VALID   = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (bus.REQ_READY !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rdy"}, {31'd0, bus.REQ_READY}, 32'd1);
    endtask

    // Called at a negedge; returns at a negedge with the block idle.
    task automatic issue(input string tag, input logic [5:0] oprn,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic imm_sel, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [31:0] e_op1,
                         input logic [31:0] e_op2, input logic [31:0] e_data);
        wait_ready(tag);
        drive_req(oprn, rs1, rs2, imm_sel, imm, rd);
        bus.RSP_READY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_op1"}, bus.ALU_OP1, e_op1);
        chk({tag, "_op2"}, bus.ALU_OP2, e_op2);
        chk({tag, "_oprn"}, {26'd0, bus.ALU_OPRN}, {26'd0, oprn});
        chk({tag, "_vld_early"}, {31'd0, bus.RSP_VALID}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_vld"}, {31'd0, bus.RSP_VALID}, 32'd1);
        chk({tag, "_data"}, bus.RSP_DATA, e_data);
        chk({tag, "_rd"}, {27'd0, bus.RSP_RD}, {27'd0, rd});
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, bus.RSP_VALID}, 32'd0);
    endtask

    initial begin
        bus.REQ_VALID   = 1'b0;
        bus.REQ_OPRN    = '0;
        bus.REQ_RS1     = '0;
        bus.REQ_RS2     = '0;
        bus.REQ_RD      = '0;
        bus.REQ_IMM_SEL = 1'b0;
        bus.REQ_IMM     = '0;
        bus.RSP_READY   = 1'b0;

        @(negedge clk);
        chk("rst_vld", {31'd0, bus.RSP_VALID}, 32'd0);
        chk("rst_op1", bus.ALU_OP1, 32'd0);
        chk("rst_op2", bus.ALU_OP2, 32'd0);
        chk("rst_oprn", {26'd0, bus.ALU_OPRN}, 32'd0);
        chk("rst_data", bus.RSP_DATA, 32'd0);
        chk("rst_rd", {27'd0, bus.RSP_RD}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.REQ_READY}, 32'd1);

        issue("imm_r1", 6'h01, 5'd0, 5'd0, 1'b1, 32'd15, 5'd1,
              32'd0, 32'd15, 32'd15);
        issue("imm_r2", 6'h01, 5'd0, 5'd0, 1'b1, 32'd3, 5'd2,
              32'd0, 32'd3, 32'd3);
        issue("sub_r3", 6'h02, 5'd1, 5'd2, 1'b0, 32'hdead, 5'd3,
              32'd15, 32'd3, 32'd12);
        issue("mov_r7", 6'h01, 5'd3, 5'd0, 1'b1, 32'd0, 5'd7,
              32'd12, 32'd0, 32'd12);
        issue("imm_r4", 6'h01, 5'd0, 5'd0, 1'b1, 32'h55, 5'd4,
              32'd0, 32'h55, 32'h55);
        issue("undef", 6'h3f, 5'd1, 5'd0, 1'b1, 32'hf0, 5'd9,
              32'd15, 32'hf0, 32'hff);

        // Backpressure: request B held valid while A waits in RESP
        wait_ready("bp_a");
        drive_req(6'h01, 5'd3, 5'd0, 1'b1, 32'h100, 5'd5);
        bus.RSP_READY = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_req(6'h01, 5'd5, 5'd0, 1'b1, 32'd1, 5'd6);
        chk("bp_busy", {31'd0, bus.REQ_READY}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_vld", {31'd0, bus.RSP_VALID}, 32'd1);
            chk("bp_data", bus.RSP_DATA, 32'd268);
            chk("bp_rd", {27'd0, bus.RSP_RD}, 32'd5);
            chk("bp_nrdy", {31'd0, bus.REQ_READY}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("bp_hold", {31'd0, bus.RSP_VALID}, 32'd1);
        bus.RSP_READY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle", {31'd0, bus.REQ_READY}, 32'd1);
        chk("bp_vld_lo", {31'd0, bus.RSP_VALID}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp_b_op1", bus.ALU_OP1, 32'd268);
        @(posedge clk);
        @(negedge clk);
        chk("bp_b_vld", {31'd0, bus.RSP_VALID}, 32'd1);
        chk("bp_b_data", bus.RSP_DATA, 32'd269);
        chk("bp_b_rd", {27'd0, bus.RSP_RD}, 32'd6);
        @(posedge clk);
        @(negedge clk);

        issue("r0_wr", 6'h01, 5'd0, 5'd0, 1'b1, 32'd7, 5'd0,
              32'd0, 32'd7, 32'd7);
        issue("r0_rd", 6'h01, 5'd0, 5'd0, 1'b1, 32'd2, 5'd8,
              32'd0, 32'd2, 32'd2);

        // Reset while EXEC targets R4
        wait_ready("rx");
        drive_req(6'h01, 5'd0, 5'd0, 1'b1, 32'd9, 5'd4);
        @(posedge clk);
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rx_op2", bus.ALU_OP2, 32'd9);
        rst = 1'b1;
        #1;
        chk("rx_vld", {31'd0, bus.RSP_VALID}, 32'd0);
        chk("rx_op1", bus.ALU_OP1, 32'd0);
        chk("rx_op2_clr", bus.ALU_OP2, 32'd0);
        chk("rx_oprn", {26'd0, bus.ALU_OPRN}, 32'd0);
        chk("rx_data", bus.RSP_DATA, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rx_ready", {31'd0, bus.REQ_READY}, 32'd1);
        issue("rx_r4", 6'h01, 5'd4, 5'd0, 1'b1, 32'd0, 5'd10,
              32'd0, 32'd0, 32'd0);
        issue("rx_r1", 6'h01, 5'd1, 5'd0, 1'b1, 32'd0, 5'd11,
              32'd0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
